// File: rtl/alu_seq.sv
// Clocked N-bit ALU with eight modes stepped by a synchronised push-button.
// Multiply is a sequential shift-add; the result drives two active-low hex digits.
module alu_seq #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in1,
    input  logic [N-1:0]     in2,
    input  logic             click,
    input  logic             start,
    output logic [2:0]       mode,
    output logic             busy,
    output logic             done,
    output logic             neg,
    output logic             cero,
    output logic             carry,
    output logic             des,
    output logic [2*N-1:0]   num,
    output logic [1:0][6:0]  out
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = (2 * N > 8) ? 2 * N : 8;

    typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR
    } op_t;

    state_t           state;
    op_t              op_r;
    logic [CW-1:0]    cnt;
    logic [N-1:0]     a_r, b_r, mplier;
    logic [2*N-1:0]   mcand, prod;
    logic             sync1, sync2, sync3;
    logic             click_edge;

    logic [N:0]       sum, diff;
    logic [2*N-1:0]   shl_w, shr_w, res;
    logic [N-1:0]     res_lo;
    logic             f_neg, f_carry, f_des;
    logic [DW-1:0]    numx;

    assign click_edge = sync2 & ~sync3;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        sum     = {1'b0, a_r} + {1'b0, b_r};
        diff    = {1'b0, a_r} - {1'b0, b_r};
        shl_w   = {{N{1'b0}}, a_r} << b_r;
        shr_w   = {a_r, {N{1'b0}}} >> b_r;
        res_lo  = '0;
        f_carry = 1'b0;
        f_des   = 1'b0;
        case (op_r)
            OP_ADD: begin
                res_lo  = sum[N-1:0];
                f_carry = sum[N];
                f_des   = (a_r[N-1] == b_r[N-1]) && (sum[N-1] != a_r[N-1]);
            end
            OP_SUB: begin
                res_lo  = diff[N-1:0];
                f_carry = diff[N];
                f_des   = (a_r[N-1] != b_r[N-1]) && (diff[N-1] != a_r[N-1]);
            end
            OP_MUL: f_carry = |prod[2*N-1:N];
            OP_AND: res_lo = a_r & b_r;
            OP_OR:  res_lo = a_r | b_r;
            OP_XOR: res_lo = a_r ^ b_r;
            // Widened shifts: the bit just past the kept field is the last one shifted out.
            OP_SHL: begin
                res_lo  = shl_w[N-1:0];
                f_carry = shl_w[N];
            end
            OP_SHR: begin
                res_lo  = shr_w[2*N-1:N];
                f_carry = shr_w[N-1];
            end
            default: ;
        endcase
        res   = (op_r == OP_MUL) ? prod : {{N{1'b0}}, res_lo};
        f_neg = (op_r != OP_MUL) && res_lo[N-1];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_r   <= OP_ADD;
            cnt    <= '0;
            a_r    <= '0;
            b_r    <= '0;
            mplier <= '0;
            mcand  <= '0;
            prod   <= '0;
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync3  <= 1'b0;
            mode   <= 3'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
            num    <= '0;
            neg    <= 1'b0;
            cero   <= 1'b0;
            carry  <= 1'b0;
            des    <= 1'b0;
        end else begin
            sync1 <= click;
            sync2 <= sync1;
            sync3 <= sync2;
            done  <= 1'b0;
            if (click_edge && !busy && state != MUL)
                mode <= mode + 3'd1;
            case (state)
                IDLE: if (start) begin
                    a_r  <= in1;
                    b_r  <= in2;
                    op_r <= op_t'(mode);
                    if (mode == 3'(OP_MUL)) begin
                        cnt    <= '0;
                        prod   <= '0;
                        mcand  <= {{N{1'b0}}, in1};
                        mplier <= in2;
                        state  <= MUL;
                    end else begin
                        state <= FIN;
                    end
                end
                MUL: begin
                    busy <= 1'b1;
                    if (mplier[0])
                        prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(N - 1))
                        state <= FIN;
                end
                FIN: begin
                    num   <= res;
                    neg   <= f_neg;
                    cero  <= (res == '0);
                    carry <= f_carry;
                    des   <= f_des;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'ha: hex7 = 7'b0001000;
            4'hb: hex7 = 7'b0000011;
            4'hc: hex7 = 7'b1000110;
            4'hd: hex7 = 7'b0100001;
            4'he: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign numx   = DW'(num);
    assign out[0] = hex7(numx[3:0]);
    assign out[1] = hex7(numx[7:4]);

endmodule
